alu_seq_unit: RTL and testbench
===============================

Name: alu_seq_unit

Overview:
- Parametrised, registered successor to the combinational ALU control decoder.
- Decodes aluop/funct into an ALU select code, executes the operation, and returns a registered result with a valid/ready handshake.
- Adds a multi-cycle unsigned multiply with HI/LO registers, MFHI/MFLO reads and illegal-funct flagging.
- Sits in the EX stage of the MIPS datapath; the stall logic uses ready_in.

Parameters:
- WIDTH, 32, operand/result width in bits (min 8).
- MULT_EN, 1, 1 = MULT/MFHI/MFLO implemented; 0 = those functs flagged illegal.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  operation request this cycle.
- ready_in  output  1  unit can accept; op accepted when valid_in & ready_in at clk edge.
- aluop  input  2  00 lw/sw (add), 01 beq (sub), 10 R-type (decode funct), 11 ori (or).
- funct  input  6  R-type function field; ignored unless aluop=10.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/imm).
- select  output  3  combinational decoded select for the current inputs (debug/compat).
- result  output  WIDTH  registered result.
- zero  output  1  registered, (result == 0).
- valid_out  output  1  one-cycle pulse, result/zero valid.
- illegal  output  1  one-cycle pulse, coincident with valid_out, on an undefined funct.
- busy  output  1  multiply in progress.

Behaviour:
- Select map: and 000, or 001, add 010, xor 011, nor 100, mfhi 101, sub 110, slt 111. MULT uses a separate internal op, not a select code.
- aluop=10 funct map:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor, 101010 slt.
  - 011000 mult, 010000 mfhi, 010010 mflo.
  - mflo uses select 101 plus an internal lo flag.
- Undefined funct: select=010, result = a+b, illegal pulses.
- Arithmetic:
  - add/sub are modulo 2^WIDTH; overflow is ignored.
  - slt is a signed compare; result = 1 or 0, zero-extended.
  - mult is unsigned a*b, 2*WIDTH bits: HI = upper half, LO = lower half.
- States: IDLE, MULT.
- ready_in = (state==IDLE).
- Single-cycle op accepted at edge N:
  - result, zero, valid_out (and illegal if applicable) update at edge N.
  - Visible during cycle N+1; latency 1.
  - Back-to-back acceptance every cycle is allowed.
- MULT accepted at edge N (IDLE):
  - Latch a/b, clear the accumulator, state -> MULT, busy=1, ready_in=0.
  - Run one shift-add iteration per edge for WIDTH edges (N+1..N+WIDTH).
  - At edge N+WIDTH: HI/LO written, result=LO, zero=(LO==0), valid_out pulses, state -> IDLE.
  - Accept-to-valid latency is WIDTH+1 edges; a new op can be accepted at edge N+WIDTH+1.
- valid_in while ready_in=0 is ignored (not queued). The requester must hold the request.
- MFHI/MFLO return the HI/LO registers as last completed. They are never reachable mid-multiply because ready_in=0.
- MULT_EN=0: mult/mfhi/mflo treated as undefined functs.
- valid_out/illegal are 0 in any cycle without a completing op; result/zero hold their last values.
- Reset (any state, including mid-multiply):
  - state=IDLE, abort the multiply, HI=LO=0.
  - result=0, zero=1, valid_out=0, illegal=0, busy=0, ready_in=1 from the cycle after the reset edge.
  - An op presented with rst high is not accepted.

Test Plan:
- Decode compatibility (combinational select, no clk):
  - aluop=00/funct=100000 -> select 010.
  - aluop=01 -> select 110.
  - aluop=10 with funct 100000/100010/100100/100101/101010 -> select 010/110/000/001/111.
- Single-cycle ops (a=5, b=7), back-to-back:
  - add -> 12, then sub -> 0xFFFFFFFE.
  - slt -> 1; slt with a=-1, b=1 -> 1.
  - sub with a=b=9 -> result 0, zero=1.
  - valid_out high in each following cycle.
- Multiply: a=0xFFFFFFFF, b=2.
  - busy/ready_in=0 for 32 cycles.
  - valid_out after 33 edges, result=0xFFFFFFFE.
  - Then mfhi -> 1, mflo -> 0xFFFFFFFE.
- Stall: valid_in with add held during a multiply -> not accepted until ready_in=1; then result = a+b exactly once.
- Illegal: aluop=10, funct=111111, a=1, b=2 -> result 3, illegal and valid_out pulse together.
- Reset mid-multiply:
  - rst at cycle 10 of a multiply -> next cycle state IDLE, busy=0, valid_out=0, result=0, zero=1.
  - Subsequent mfhi -> 0.

Source files
------------

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered ALU with aluop/funct decode and multi-cycle shift-add multiply
// Single-cycle ops complete in one edge; MULT holds ready_in low for WIDTH iterations.
module alu_seq_unit #(
  parameter int WIDTH   = 32,
  parameter bit MULT_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       select,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out,
  output logic             illegal,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_MFHI, OP_MFLO, OP_SUB, OP_SLT, OP_MULT
  } op_e;

  typedef enum logic [0:0] {S_IDLE, S_MULT} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, valid_q, illegal_q;
  logic [WIDTH-1:0] mcand_q, acc_q, mq_q;
  logic [CNT_W-1:0] cnt_q;

  op_e              op_sel;
  logic             dec_illegal;
  logic [WIDTH-1:0] alu_res;
  logic             slt_bit;

  logic [WIDTH:0]     add_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   acc_d, mq_d;
  logic               last_iter;

  // Undefined functs fall back to add and raise dec_illegal.
  always_comb begin
    op_sel      = OP_ADD;
    dec_illegal = 1'b0;
    case (aluop)
      2'b00: op_sel = OP_ADD;
      2'b01: op_sel = OP_SUB;
      2'b11: op_sel = OP_OR;
      default: begin
        case (funct)
          6'b100000: op_sel = OP_ADD;
          6'b100010: op_sel = OP_SUB;
          6'b100100: op_sel = OP_AND;
          6'b100101: op_sel = OP_OR;
          6'b100110: op_sel = OP_XOR;
          6'b100111: op_sel = OP_NOR;
          6'b101010: op_sel = OP_SLT;
          6'b011000: if (MULT_EN) op_sel = OP_MULT; else dec_illegal = 1'b1;
          6'b010000: if (MULT_EN) op_sel = OP_MFHI; else dec_illegal = 1'b1;
          6'b010010: if (MULT_EN) op_sel = OP_MFLO; else dec_illegal = 1'b1;
          default:   dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    select = 3'b010;
    case (op_sel)
      OP_AND:  select = 3'b000;
      OP_OR:   select = 3'b001;
      OP_ADD:  select = 3'b010;
      OP_XOR:  select = 3'b011;
      OP_NOR:  select = 3'b100;
      OP_MFHI: select = 3'b101;
      OP_MFLO: select = 3'b101;
      OP_SUB:  select = 3'b110;
      OP_SLT:  select = 3'b111;
      default: select = 3'b010;
    endcase
  end

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    alu_res = a + b;
    case (op_sel)
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_ADD:  alu_res = a + b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      default: alu_res = a + b;
    endcase
  end

  // One shift-add step: {acc, mq} holds the partial product, mq's low bit picks the addend.
  always_comb begin
    add_d     = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_d    = {add_d, mq_q[WIDTH-1:1]};
    acc_d     = prod_d[2*WIDTH-1:WIDTH];
    mq_d      = prod_d[WIDTH-1:0];
    last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_in) begin
            if (op_sel == OP_MULT) begin
              mcand_q <= a;
              mq_q    <= b;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MULT;
            end else begin
              result_q  <= alu_res;
              zero_q    <= (alu_res == '0);
              valid_q   <= 1'b1;
              illegal_q <= dec_illegal;
            end
          end
        end
        S_MULT: begin
          acc_q <= acc_d;
          mq_q  <= mq_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            hi_q     <= acc_d;
            lo_q     <= mq_d;
            result_q <= mq_d;
            zero_q   <= (mq_d == '0);
            valid_q  <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_in  = (state_q == S_IDLE);
  assign busy      = (state_q == S_MULT);
  assign result    = result_q;
  assign zero      = zero_q;
  assign valid_out = valid_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed and randomized checks of alu_seq_unit against an arithmetic model
module tb_alu_seq_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in;
  logic         ready_in;
  logic [1:0]   aluop;
  logic [5:0]   funct;
  logic [W-1:0] a, b, result;
  logic [2:0]   select;
  logic         zero, valid_out, illegal, busy;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(W), .MULT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .aluop(aluop), .funct(funct), .a(a), .b(b), .select(select),
    .result(result), .zero(zero), .valid_out(valid_out),
    .illegal(illegal), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {is_mult, illegal, result} from the instruction semantics.
  function automatic logic [W+1:0] ref_op(input logic [1:0] op, input logic [5:0] fn,
                                          input logic [W-1:0] x, input logic [W-1:0] y);
    case (op)
      2'd0: return {2'b00, x + y};
      2'd1: return {2'b00, x - y};
      2'd3: return {2'b00, x | y};
      default: begin
        case (fn)
          6'h20: return {2'b00, x + y};
          6'h22: return {2'b00, x - y};
          6'h24: return {2'b00, x & y};
          6'h25: return {2'b00, x | y};
          6'h26: return {2'b00, x ^ y};
          6'h27: return {2'b00, ~(x | y)};
          6'h2a: return {2'b00, (($signed(x) < $signed(y)) ? W'(1) : W'(0))};
          6'h18: return {2'b10, W'(0)};
          6'h10: return {2'b00, hi_m};
          6'h12: return {2'b00, lo_m};
          default: return {2'b01, x + y};
        endcase
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] m;
    logic [W-1:0] r;
    logic [63:0]  p;
    m = ref_op(op, fn, x, y);
    r = m[W-1:0];
    chk("ready_before", ready_in, 1);
    aluop = op; funct = fn; a = x; b = y; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    if (m[W+1]) begin
      p = {32'b0, x} * {32'b0, y};
      for (int i = 0; i < W; i++) begin
        chk("mult_busy", {busy, ready_in, valid_out}, 3'b100);
        @(posedge clk); #1;
      end
      hi_m = p[63:32];
      lo_m = p[31:0];
      r    = p[31:0];
    end
    chk("valid_illegal", {valid_out, illegal}, {1'b1, m[W]});
    chk("result", result, r);
    chk("zero", zero, (r == '0));
    chk("idle_after", {busy, ready_in}, 2'b01);
  endtask

  logic [5:0] fns [12];
  logic [1:0] rop;
  logic [5:0] rfn;
  logic [W-1:0] rx, ry;

  initial begin
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h18, 6'h10, 6'h12, 6'h3f, 6'h00};
    rst = 1'b1; valid_in = 1'b0; aluop = 2'b00; funct = 6'h20; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", {result, zero, valid_out, illegal, busy, ready_in}, {32'h0, 5'b10001});

    // Combinational decode
    aluop = 2'b00; funct = 6'h20; #1; chk("sel_lw", select, 3'b010);
    aluop = 2'b01; #1; chk("sel_beq", select, 3'b110);
    aluop = 2'b10; funct = 6'h20; #1; chk("sel_add", select, 3'b010);
    funct = 6'h22; #1; chk("sel_sub", select, 3'b110);
    funct = 6'h24; #1; chk("sel_and", select, 3'b000);
    funct = 6'h25; #1; chk("sel_or", select, 3'b001);
    funct = 6'h2a; #1; chk("sel_slt", select, 3'b111);
    funct = 6'h12; #1; chk("sel_mflo", select, 3'b101);

    // Back-to-back single-cycle ops
    run_op(2'b10, 6'h20, 5, 7);
    chk("add_const", result, 32'd12);
    run_op(2'b10, 6'h22, 5, 7);
    chk("sub_const", result, 32'hFFFF_FFFE);
    run_op(2'b10, 6'h2a, 5, 7);
    run_op(2'b10, 6'h2a, 32'hFFFF_FFFF, 1);
    chk("slt_neg_const", result, 32'd1);
    run_op(2'b01, 6'h00, 9, 9);
    chk("sub_zero_const", zero, 1);

    // Multiply then HI/LO reads
    run_op(2'b10, 6'h18, 32'hFFFF_FFFF, 2);
    chk("mult_lo_const", result, 32'hFFFF_FFFE);
    run_op(2'b10, 6'h10, 0, 0);
    chk("mfhi_const", result, 32'd1);
    run_op(2'b10, 6'h12, 0, 0);

    // Stall: add held during a multiply is taken exactly once afterwards
    aluop = 2'b10; funct = 6'h18; a = 32'd1234; b = 32'd5678; valid_in = 1'b1;
    @(posedge clk); #1;
    aluop = 2'b00; funct = 6'h00; a = 32'd40; b = 32'd2;
    for (int i = 0; i < W; i++) begin
      chk("stall_ready", {ready_in, valid_out}, 2'b00);
      @(posedge clk); #1;
    end
    chk("stall_mult", {valid_out, result}, {1'b1, 32'd7006652});
    hi_m = 0; lo_m = 32'd7006652;
    @(posedge clk); #1;
    valid_in = 1'b0;
    chk("stall_add", {valid_out, result}, {1'b1, 32'd42});
    @(posedge clk); #1;
    chk("stall_once", valid_out, 0);

    // Illegal funct
    run_op(2'b10, 6'h3f, 1, 2);
    chk("illegal_const", {illegal, result}, {1'b1, 32'd3});
    @(posedge clk); #1;
    chk("illegal_drop", {valid_out, illegal, result}, {2'b00, 32'd3});

    // Reset mid-multiply
    aluop = 2'b10; funct = 6'h18; a = 32'hDEAD_BEEF; b = 32'h1234_5678; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("pre_reset_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_reset", {busy, ready_in, valid_out, zero, result}, {4'b0101, 32'h0});
    hi_m = '0; lo_m = '0;
    run_op(2'b10, 6'h10, 3, 4);
    chk("mfhi_after_reset", result, 0);

    // Randomized ops with occasional idle cycles
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom_range(0, 3));
      rfn = fns[$urandom_range(0, 11)];
      if (rfn == 6'h00) rfn = 6'($urandom);
      rx = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      ry = ($urandom_range(0, 3) == 0) ? rx : W'($urandom);
      run_op(rop, rfn, rx, ry);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        chk("rand_idle", {valid_out, illegal}, 2'b00);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
